// File: rtl/gate_sweep_checker.sv
// Truth-table sweeper and checker for an N-input, single-output combinational
// gate. Steps vec through 0..2^N-1, holds each vector HOLD cycles, then compares
// dut_y against the function selected by op. It counts the mismatching vectors
// and remembers the first one.
module gate_sweep_checker #(
    parameter int N    = 2,
    parameter int HOLD = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic         dut_y,
    output logic [N-1:0] vec,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic         first_err_valid,
    output logic [N-1:0] first_err_vec
);

    // A hold counter of at least one bit keeps HOLD=1 legal.
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N-1:0]  VEC_MAX   = {N{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  vec_q, vec_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [2:0]    op_q, op_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [N:0]    err_cnt_q, err_cnt_d;
    logic          fev_q, fev_d;
    logic [N-1:0]  fe_vec_q, fe_vec_d;
    logic          mismatch_s;

    // Reference gate function. Reserved op codes fall back to NAND.
    function automatic logic expected_fn(input logic [2:0] f, input logic [N-1:0] v);
        logic r;
        case (f)
            3'd0:    r = ~(&v);
            3'd1:    r = &v;
            3'd2:    r = |v;
            3'd3:    r = ~(|v);
            3'd4:    r = ^v;
            3'd5:    r = ~(^v);
            default: r = ~(&v);
        endcase
        return r;
    endfunction

    // Compare the gate output with the reference for the vector currently driven.
    always_comb begin
        mismatch_s = (dut_y != expected_fn(op_q, vec_q));
    end

    // Next-state and result logic for the IDLE / SWEEP / DONE controller.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        hold_d   = hold_q;
        op_d     = op_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_cnt_d = err_cnt_q;
        fev_d    = fev_q;
        fe_vec_d = fe_vec_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_SWEEP;
                    vec_d     = {N{1'b0}};
                    hold_d    = {HW{1'b0}};
                    op_d      = op;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_cnt_d = {(N+1){1'b0}};
                    fev_d     = 1'b0;
                    fe_vec_d  = {N{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_SWEEP: begin
                if (hold_q == HOLD_LAST) begin
                    if (mismatch_s) begin
                        err_cnt_d = err_cnt_q + (N+1)'(1'b1);
                        if (!fev_q) begin
                            fev_d    = 1'b1;
                            fe_vec_d = vec_q;
                        end else begin
                            fev_d = fev_q;
                        end
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    if (vec_q == VEC_MAX) begin
                        // Last vector sampled: vec stays at its final value.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == {(N+1){1'b0}});
                    end else begin
                        vec_d  = vec_q + N'(1'b1);
                        hold_d = {HW{1'b0}};
                    end
                end else begin
                    hold_d = hold_q + HW'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= {N{1'b0}};
            hold_q    <= {HW{1'b0}};
            op_q      <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= {(N+1){1'b0}};
            fev_q     <= 1'b0;
            fe_vec_q  <= {N{1'b0}};
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            hold_q    <= hold_d;
            op_q      <= op_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            fev_q     <= fev_d;
            fe_vec_q  <= fe_vec_d;
        end
    end

    assign vec             = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fe_vec_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: one instance with N=2, HOLD=5 and one
// with N=3, HOLD=1. Each instance has a small gate model on dut_y.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=2, HOLD=5
    logic       rst_a, start_a, dut_y_a, busy_a, done_a, pass_a, fev_a;
    logic [2:0] op_a;
    logic [1:0] vec_a, fevec_a;
    logic [2:0] err_a;
    int         mode_a;   // 0: ideal NAND, 1: stuck at 0

    // Instance B: N=3, HOLD=1
    logic       rst_b, start_b, dut_y_b, busy_b, done_b, pass_b, fev_b;
    logic [2:0] op_b;
    logic [2:0] vec_b, fevec_b;
    logic [3:0] err_b;
    int         mode_b;   // 0: ideal XOR3, 1: ideal NAND3

    always_comb dut_y_a = (mode_a == 1) ? 1'b0 : ~(&vec_a);
    always_comb dut_y_b = (mode_b == 1) ? ~(&vec_b) : ^vec_b;

    gate_sweep_checker #(.N(2), .HOLD(5)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .op(op_a), .dut_y(dut_y_a),
        .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .first_err_valid(fev_a), .first_err_vec(fevec_a)
    );

    gate_sweep_checker #(.N(3), .HOLD(1)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .op(op_b), .dut_y(dut_y_b),
        .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .first_err_valid(fev_b), .first_err_vec(fevec_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on one instance, then follow the sweep until busy drops.
    // Returns busy length, count of vec steps off the expected schedule, and
    // err_cnt/done seen on the first busy cycle. disturb pokes start/op mid-sweep.
    task automatic sweep(input int sel, input logic [2:0] op_v, input bit disturb,
                         output int nbusy, output int vec_bad,
                         output int err0, output int done0);
        int hold_v;
        int v;
        hold_v = (sel == 0) ? 5 : 1;
        if (sel == 0) begin start_a = 1'b1; op_a = op_v; end
        else          begin start_b = 1'b1; op_b = op_v; end
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        nbusy   = 0;
        vec_bad = 0;
        err0    = (sel == 0) ? int'(err_a) : int'(err_b);
        done0   = (sel == 0) ? int'(done_a) : int'(done_b);
        while (((sel == 0) ? busy_a : busy_b) && nbusy < 200) begin
            v = (sel == 0) ? int'(vec_a) : int'(vec_b);
            if (v != nbusy / hold_v) vec_bad++;
            if (disturb && nbusy == 7) begin start_a = 1'b1; op_a = 3'd2; end
            if (disturb && nbusy == 8) begin start_a = 1'b0; end
            nbusy++;
            step();
        end
    endtask

    initial begin
        int nb, vb, e0, d0;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        op_a = 3'd0; op_b = 3'd0; mode_a = 0; mode_b = 0;
        step();
        step();
        check("rst_vec",   {30'd0, vec_a}, 32'd0);
        check("rst_busy",  {31'd0, busy_a}, 32'd0);
        check("rst_done",  {31'd0, done_a}, 32'd0);
        check("rst_pass",  {31'd0, pass_a}, 32'd0);
        check("rst_err",   {29'd0, err_a}, 32'd0);
        check("rst_fev",   {31'd0, fev_a}, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        step();

        // Ideal NAND, op=NAND
        sweep(0, 3'd0, 1'b0, nb, vb, e0, d0);
        check("nand_busy_len", nb, 32'd20);
        check("nand_vec_seq",  vb, 32'd0);
        check("nand_done",     {31'd0, done_a}, 32'd1);
        check("nand_pass",     {31'd0, pass_a}, 32'd1);
        check("nand_err",      {29'd0, err_a}, 32'd0);
        check("nand_fev",      {31'd0, fev_a}, 32'd0);
        step(); step(); step();
        check("done_sticky",   {31'd0, done_a}, 32'd1);
        check("vec_no_wrap",   {30'd0, vec_a}, 32'd3);

        // Stuck-at-0 output, restart from DONE
        mode_a = 1;
        sweep(0, 3'd0, 1'b0, nb, vb, e0, d0);
        check("stuck_busy_len", nb, 32'd20);
        check("stuck_err",      {29'd0, err_a}, 32'd3);
        check("stuck_pass",     {31'd0, pass_a}, 32'd0);
        check("stuck_fev",      {31'd0, fev_a}, 32'd1);
        check("stuck_fevec",    {30'd0, fevec_a}, 32'd0);

        // op=AND against a NAND gate: every vector mismatches
        mode_a = 0;
        sweep(0, 3'd1, 1'b0, nb, vb, e0, d0);
        check("and_err",   {29'd0, err_a}, 32'd4);
        check("and_fevec", {30'd0, fevec_a}, 32'd0);
        check("and_pass",  {31'd0, pass_a}, 32'd0);
        sweep(0, 3'd0, 1'b0, nb, vb, e0, d0);
        check("restart_err_cleared", e0, 32'd0);
        check("restart_done_cleared", d0, 32'd0);
        check("restart_err",  {29'd0, err_a}, 32'd0);
        check("restart_pass", {31'd0, pass_a}, 32'd1);

        // start and op poked mid-sweep are ignored
        sweep(0, 3'd0, 1'b1, nb, vb, e0, d0);
        check("disturb_busy_len", nb, 32'd20);
        check("disturb_vec_seq",  vb, 32'd0);
        check("disturb_pass",     {31'd0, pass_a}, 32'd1);

        // Reset in the middle of a sweep
        mode_a = 1;
        start_a = 1'b1; op_a = 3'd0;
        step();
        start_a = 1'b0;
        nb = 0;
        while (vec_a != 2'd2 && nb < 100) begin nb++; step(); end
        check("abort_reached_vec2", {30'd0, vec_a}, 32'd2);
        rst_a = 1'b1;
        step();
        check("abort_vec",   {30'd0, vec_a}, 32'd0);
        check("abort_busy",  {31'd0, busy_a}, 32'd0);
        check("abort_done",  {31'd0, done_a}, 32'd0);
        check("abort_err",   {29'd0, err_a}, 32'd0);
        check("abort_fev",   {31'd0, fev_a}, 32'd0);
        check("abort_fevec", {30'd0, fevec_a}, 32'd0);
        rst_a = 1'b0;
        step(); step(); step();
        check("abort_idle_busy", {31'd0, busy_a}, 32'd0);
        check("abort_idle_done", {31'd0, done_a}, 32'd0);

        // N=3, HOLD=1, XOR3 model, op=XOR
        mode_b = 0;
        sweep(1, 3'd4, 1'b0, nb, vb, e0, d0);
        check("xor_busy_len", nb, 32'd8);
        check("xor_vec_seq",  vb, 32'd0);
        check("xor_done",     {31'd0, done_b}, 32'd1);
        check("xor_pass",     {31'd0, pass_b}, 32'd1);
        check("xor_err",      {28'd0, err_b}, 32'd0);
        check("xor_vec_end",  {29'd0, vec_b}, 32'd7);

        // Reserved op=6 behaves as NAND
        mode_b = 1;
        sweep(1, 3'd6, 1'b0, nb, vb, e0, d0);
        check("rsv_pass", {31'd0, pass_b}, 32'd1);
        check("rsv_err",  {28'd0, err_b}, 32'd0);

        // Reserved op=6 against XOR3: mismatches at vectors 0,3,5,6,7
        mode_b = 0;
        sweep(1, 3'd6, 1'b0, nb, vb, e0, d0);
        check("rsv_xor_err",   {28'd0, err_b}, 32'd5);
        check("rsv_xor_fevec", {29'd0, fevec_b}, 32'd0);
        check("rsv_xor_pass",  {31'd0, pass_b}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
